// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word-aligned requests with byte enables, lane-replicated
// store data and right-justified load data. Optional misalignment trap: PHILV_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int N            = 32,
  parameter int TIMEOUT      = 255,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3,
  parameter logic [OPCODE_WIDTH-1:0] OPCODE_LOAD  = 7'b0000011,
  parameter logic [OPCODE_WIDTH-1:0] OPCODE_STORE = 7'b0100011
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  input  logic [N-1:0]            addr,
  input  logic [N-1:0]            wdata,
  output logic                    stall,
  output logic                    done,
  output logic                    err,
  output logic [N-1:0]            rdata_out,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [N-1:0]            mem_addr,
  output logic [3:0]              mem_be,
  output logic [N-1:0]            mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [N-1:0]            mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             err_q;
  logic             abort;
  logic             mem_op;
  logic             is_store;
  logic             misaligned;
  logic             timeout_hit;
  logic [3:0]       be_calc;
  logic [N-1:0]     wdata_calc;
  logic [N-1:0]     load_shift;
  logic             unused_funct3;

  // The sign bit of funct3 belongs to the extension stage downstream.
  assign unused_funct3 = ^funct3[FUNCT3_WIDTH-1:2];

  assign is_store    = (opcode == OPCODE_STORE);
  assign mem_op      = start && ((opcode == OPCODE_LOAD) || is_store);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef PHILV_MISALIGN_TRAP_EN
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      (funct3[1] && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {addr[1], 1'b0};
        wdata_calc = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Logical right shift only; sign/zero extension happens in the next stage.
  always_comb begin
    load_shift = mem_rdata;
    case (size_q)
      2'b00:   load_shift = mem_rdata >> {off_q, 3'b000};
      2'b01:   load_shift = mem_rdata >> {off_q[1], 4'b0000};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    stall   = 1'b0;
    mem_req = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          state_d = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_d = mem_we ? DONE : WAIT;
        end else if (timeout_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err = (state_q == DONE) && err_q;

  // Entry to REQ is only from IDLE, so clearing in IDLE restarts the count per access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      err_q     <= 1'b0;
      rdata_out <= '0;
    end else begin
      if ((state_q == IDLE) && mem_op) begin
        mem_addr  <= {addr[N-1:2], 2'b00};
        mem_be    <= be_calc;
        mem_wdata <= wdata_calc;
        mem_we    <= is_store;
        size_q    <= funct3[1:0];
        off_q     <= addr[1:0];
        err_q     <= misaligned;
      end
      if (abort) begin
        err_q     <= 1'b1;
        rdata_out <= '0;
      end else if ((state_q == WAIT) && mem_rvalid) begin
        rdata_out <= load_shift;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// checked against an arithmetic reference model.
module tb_load_store_unit;

  localparam int TIMEOUT = 255;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.N(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .err(err),
    .rdata_out(rdata_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on byte offsets and lane sizes.
  function automatic bit m_misaligned(input int sz, input logic [31:0] a);
`ifdef PHILV_MISALIGN_TRAP_EN
    return ((sz == 1) && (a % 2 != 0)) || ((sz == 2) && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_be(input int sz, input logic [31:0] a);
    if (sz == 0) return 32'(1 << (a % 4));
    if (sz == 1) return 32'(3 << (2 * ((a / 2) % 2)));
    return 32'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] w);
    if (sz == 0) return (w % 256) * 32'h0101_0101;
    if (sz == 1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int sz, input logic [31:0] a, input logic [31:0] rd);
    if (sz == 0) return rd / (32'd1 << (8 * (a % 4)));
    if (sz == 1) return rd / (32'd1 << (16 * ((a / 2) % 2)));
    return rd;
  endfunction

  // One access: grant on REQ cycle index g, read data on WAIT cycle index r.
  // Stray rvalid is driven during REQ and stray gnt during WAIT; both must be ignored.
  task automatic applyStimulus(input bit is_store, input int sz, input logic [31:0] a,
                               input logic [31:0] w, input logic [31:0] rd,
                               input int g, input int r, input string tag);
    bit trap;
    int done_at;
    logic [31:0] exp_rd;
    trap    = m_misaligned(sz, a);
    done_at = trap ? 1 : (is_store ? g + 2 : g + r + 3);
    exp_rd  = (!is_store && !trap) ? m_load(sz, a, rd) : last_rdata;
    @(posedge clk); #1;
    start      = 1'b1;
    opcode     = is_store ? OP_STORE : OP_LOAD;
    funct3     = {1'($urandom % 2), 2'(sz)};
    addr       = a;
    wdata      = w;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    checkOutput({tag, " stall_c0"}, 32'(stall), 32'd1);
    for (int t = 1; t <= done_at; t++) begin
      @(posedge clk); #1;
      start      = 1'b0;
      addr       = $urandom;
      wdata      = $urandom;
      mem_gnt    = (t == g + 1) || (t > g + 1 && !is_store);
      mem_rvalid = (t <= g + 1) || (t == g + 2 + r);
      mem_rdata  = (t == g + 2 + r) ? rd : ~rd;
      #1;
      if (t < done_at) begin
        checkOutput({tag, " stall"}, 32'(stall), 32'd1);
        checkOutput({tag, " done_early"}, 32'(done), 32'd0);
        checkOutput({tag, " mem_req"}, 32'(mem_req), 32'(t <= g + 1));
        if (t == 1) begin
          checkOutput({tag, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
          checkOutput({tag, " mem_be"}, 32'(mem_be), m_be(sz, a));
          checkOutput({tag, " mem_we"}, 32'(mem_we), 32'(is_store));
          if (is_store) checkOutput({tag, " mem_wdata"}, mem_wdata, m_wdata(sz, w));
        end
      end else begin
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " stall_done"}, 32'(stall), 32'd0);
        checkOutput({tag, " err"}, 32'(err), 32'(trap));
        checkOutput({tag, " req_done"}, 32'(mem_req), 32'd0);
        checkOutput({tag, " rdata_out"}, rdata_out, exp_rd);
      end
    end
    @(posedge clk); #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    checkOutput({tag, " done_pulse"}, 32'(done), 32'd0);
    last_rdata = exp_rd;
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; opcode = 7'h0; funct3 = 3'h0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset rdata", rdata_out, 32'd0);
    checkOutput("reset req", 32'(mem_req), 32'd0);
    checkOutput("reset we", 32'(mem_we), 32'd0);
    checkOutput("reset addr", mem_addr, 32'd0);
    checkOutput("reset be", 32'(mem_be), 32'd0);
    checkOutput("reset wdata", mem_wdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    applyStimulus(1'b1, 0, 32'h1003, 32'hAABB_CCDD, 32'h0, 0, 0, "SB");
    applyStimulus(1'b0, 1, 32'h2002, 32'h0, 32'h8123_4567, 3, 2, "LH");
    applyStimulus(1'b0, 2, 32'h3001, 32'h0, 32'h1234_5678, 0, 0, "LW_mis");
    applyStimulus(1'b1, 1, 32'h2000, 32'h1357_9BDF, 32'h0, 1, 0, "SH");

    // Grant never arrives: abort after TIMEOUT cycles in REQ.
    @(posedge clk); #1;
    start = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; addr = 32'h4000;
    t = 0;
    for (int k = 1; k <= TIMEOUT + 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      if (done) begin
        t = k;
        break;
      end
    end
    checkOutput("TO latency", 32'(t), 32'(TIMEOUT + 1));
    checkOutput("TO err", 32'(err), 32'd1);
    checkOutput("TO rdata", rdata_out, 32'd0);
    checkOutput("TO req", 32'(mem_req), 32'd0);
    last_rdata = 32'h0;
    @(posedge clk); #1;

    // Reset while waiting for read data.
    applyStimulus(1'b0, 2, 32'h5000, 32'h0, 32'hCAFE_F00D, 0, 0, "LW_pre");
    @(posedge clk); #1;
    start = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; addr = 32'h6000;
    @(posedge clk); #1;
    start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    checkOutput("WAIT stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("RST stall", 32'(stall), 32'd0);
    checkOutput("RST req", 32'(mem_req), 32'd0);
    checkOutput("RST rdata", rdata_out, 32'd0);
    checkOutput("RST addr", mem_addr, 32'd0);
    checkOutput("RST be", 32'(mem_be), 32'd0);
    checkOutput("RST we", 32'(mem_we), 32'd0);
    checkOutput("RST done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    #1;
    checkOutput("stale rvalid", rdata_out, 32'd0);
    last_rdata = 32'h0;
    applyStimulus(1'b0, 0, 32'h0000_0001, 32'h0, 32'h0000_FF00, 1, 1, "LBU");

    // Non-memory opcode must not stall or request.
    @(posedge clk); #1;
    start = 1'b1; opcode = 7'b0110011;
    #1;
    checkOutput("ALU stall", 32'(stall), 32'd0);
    checkOutput("ALU req", 32'(mem_req), 32'd0);
    repeat (2) begin
      @(posedge clk); #2;
      checkOutput("ALU idle req", 32'(mem_req), 32'd0);
      checkOutput("ALU idle done", 32'(done), 32'd0);
    end
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom % 2), int'($urandom % 3), $urandom, $urandom, $urandom,
                    int'($urandom % 4), int'($urandom % 4), "RND");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
